// File: rtl/dtcm_arb_pkg.sv
// Shared types and defaults for the DTCM CPU/DMA arbiter.
package dtcm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int DTCM_ARB_MAX_WAIT_DEF = 8;
    localparam int DTCM_ARB_CNT_W        = 8;

endpackage

// File: rtl/dtcm_arbiter_if.sv
// CPU, DMA and DTCM-side signals of the arbiter; slave = arbiter view, master = environment view.
interface dtcm_arbiter_if #(
    parameter int AW = 32
);
    // Handshake: cpu_en is a request for this cycle and must be held while cpu_stall=1;
    // dma_req is held stable until dma_gnt=1 (accepted in that same cycle); read data
    // returns one cycle after acceptance (cpu_rdata unqualified, dma_rdata with dma_rvalid).
    logic          cpu_en;
    logic [3:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic [3:0]    dma_wen;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;

    logic          mem_en;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_wen, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_wen, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dtcm_arb_starve.sv
// Saturating count of consecutive cycles a DMA request has gone ungranted.
module dtcm_arb_starve
    import dtcm_arb_pkg::*;
#(
    parameter int MAX_WAIT = DTCM_ARB_MAX_WAIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic                      gnt,
    output logic                      force_dma,
    output logic [DTCM_ARB_CNT_W-1:0] wait_cnt
);

    localparam logic [DTCM_ARB_CNT_W-1:0] CNT_MAX = DTCM_ARB_CNT_W'(MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset || !req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_dma = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/dtcm_arbiter.sv
// Fixed-priority CPU/DMA arbiter for the single-port DTCM with read-data steering.
// Optional DMA starvation guard enabled by defining DTCM_ARB_STARVE_EN.
module dtcm_arbiter
    import dtcm_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int MAX_WAIT = DTCM_ARB_MAX_WAIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    dtcm_arbiter_if.slave             bus,
    output owner_t                    dbg_owner,
    output logic [DTCM_ARB_CNT_W-1:0] dbg_wait_cnt
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dtcm_arbiter: MAX_WAIT must be in 1..255");
    end

    logic   force_dma;
    logic   cpu_sel;
    logic   dma_sel;
    owner_t owner;

`ifdef DTCM_ARB_STARVE_EN
    dtcm_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.dma_req),
        .gnt       (dma_sel),
        .force_dma (force_dma),
        .wait_cnt  (dbg_wait_cnt)
    );
    assign bus.cpu_stall = bus.cpu_en & dma_sel;
`else
    assign force_dma     = 1'b0;
    assign dbg_wait_cnt  = '0;
    assign bus.cpu_stall = 1'b0;
`endif

    // Selection is gated by reset so nothing reaches the DTCM while in reset.
    always_comb begin
        cpu_sel = !reset && bus.cpu_en && !(force_dma && bus.dma_req);
        dma_sel = !reset && bus.dma_req && !cpu_sel;
    end

    always_comb begin
        bus.mem_en    = cpu_sel | dma_sel;
        bus.mem_wen   = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_sel) begin
            bus.mem_wen   = bus.cpu_wen;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (dma_sel) begin
            bus.mem_wen   = bus.dma_wen;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end
    end

    assign bus.dma_gnt = dma_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else if (cpu_sel && bus.cpu_wen == 4'd0) begin
            owner <= OWN_CPU;
        end else if (dma_sel && bus.dma_wen == 4'd0) begin
            owner <= OWN_DMA;
        end else begin
            owner <= OWN_NONE;
        end
    end

    // Masking with reset drops a response whose grant preceded a reset cycle.
    always_comb begin
        bus.cpu_rdata  = (owner == OWN_CPU && !reset) ? bus.mem_rdata : 32'd0;
        bus.dma_rdata  = (owner == OWN_DMA && !reset) ? bus.mem_rdata : 32'd0;
        bus.dma_rvalid = (owner == OWN_DMA && !reset);
    end

    assign dbg_owner = owner;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Randomized scoreboard bench for dtcm_arbiter; honours DTCM_ARB_STARVE_EN like the design.
module tb_dtcm_arbiter;
    import dtcm_arb_pkg::*;

    localparam int MAX_WAIT = 8;

    logic clk;
    logic reset;
    owner_t dbg_owner;
    logic [7:0] dbg_wait_cnt;

    dtcm_arbiter_if #(.AW(32)) bus ();

    dtcm_arbiter #(
        .AW       (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dbg_owner    (dbg_owner),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DTCM behaviour (environment) ----------------
    logic [31:0] dtcm [256];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_wen == 4'd0) bus.mem_rdata <= dtcm[bus.mem_addr[9:2]];
        else                                   bus.mem_rdata <= $urandom;
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wen[b]) dtcm[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [256];
    logic [63:0] cpu_exp_q[$];   // {due_cycle, data}
    logic [63:0] dma_exp_q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_on = 0;
    int          waited = 0;     // consecutive ungranted DMA cycles, capped at MAX_WAIT
    owner_t      cur_owner = OWN_NONE;
    owner_t      next_owner = OWN_NONE;

    bit          e_cpu, e_dma, e_stall;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [7:0]  e_wait;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void write_ref(logic [31:0] addr, logic [3:0] wen, logic [31:0] wdata);
        for (int b = 0; b < 4; b++)
            if (wen[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    endfunction

    task automatic predict(input bit rst);
        bit forced;
`ifdef DTCM_ARB_STARVE_EN
        forced = (waited >= MAX_WAIT);
        e_wait = 8'(waited);
`else
        forced = 1'b0;
        e_wait = 8'd0;
`endif
        cur_owner = next_owner;
        if (rst) begin
            e_cpu = 0;
            e_dma = 0;
            if (cpu_exp_q.size() > 0 && cpu_exp_q[0][63:32] == 32'(cyc)) void'(cpu_exp_q.pop_front());
            if (dma_exp_q.size() > 0 && dma_exp_q[0][63:32] == 32'(cyc)) void'(dma_exp_q.pop_front());
        end else begin
            e_cpu = bus.cpu_en && !(forced && bus.dma_req);
            e_dma = bus.dma_req && !e_cpu;
        end
        e_stall = bus.cpu_en && e_dma;
        e_wen = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
        next_owner = OWN_NONE;
        if (e_cpu) begin
            e_wen = bus.cpu_wen; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
            if (bus.cpu_wen == 4'd0) begin
                cpu_exp_q.push_back({32'(cyc + 1), ref_mem[bus.cpu_addr[9:2]]});
                next_owner = OWN_CPU;
            end else write_ref(bus.cpu_addr, bus.cpu_wen, bus.cpu_wdata);
        end else if (e_dma) begin
            e_wen = bus.dma_wen; e_addr = bus.dma_addr; e_wdata = bus.dma_wdata;
            if (bus.dma_wen == 4'd0) begin
                dma_exp_q.push_back({32'(cyc + 1), ref_mem[bus.dma_addr[9:2]]});
                next_owner = OWN_DMA;
            end else write_ref(bus.dma_addr, bus.dma_wen, bus.dma_wdata);
        end
        if (rst || !bus.dma_req || e_dma) waited = 0;
        else if (waited < MAX_WAIT)        waited++;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rst,
                         input bit c_en, input logic [3:0] c_wen, input logic [31:0] c_addr, input logic [31:0] c_wdata,
                         input bit d_req, input logic [3:0] d_wen, input logic [31:0] d_addr, input logic [31:0] d_wdata);
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        bus.cpu_en = c_en; bus.cpu_wen = c_wen; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wdata;
        bus.dma_req = d_req; bus.dma_wen = d_wen; bus.dma_addr = d_addr; bus.dma_wdata = d_wdata;
        predict(rst);
        mon_on = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        return {24'd0, 6'($urandom_range(63, 0)), 2'b00};
    endfunction

    function automatic logic [3:0] rnd_wen();
        return ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] exp_c, exp_d;
        bit          exp_v;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("mem_en", 32'(bus.mem_en), 32'(e_cpu | e_dma));
                chk("dma_gnt", 32'(bus.dma_gnt), 32'(e_dma));
                chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
                chk("mem_wen", 32'(bus.mem_wen), 32'(e_wen));
                if (e_cpu | e_dma) begin
                    chk("mem_addr", bus.mem_addr, e_addr);
                    chk("mem_wdata", bus.mem_wdata, e_wdata);
                end
                exp_c = 32'd0;
                if (cpu_exp_q.size() > 0 && cpu_exp_q[0][63:32] == 32'(cyc)) exp_c = cpu_exp_q.pop_front()[31:0];
                chk("cpu_rdata", bus.cpu_rdata, exp_c);
                exp_d = 32'd0;
                exp_v = 0;
                if (dma_exp_q.size() > 0 && dma_exp_q[0][63:32] == 32'(cyc)) begin
                    exp_d = dma_exp_q.pop_front()[31:0];
                    exp_v = 1;
                end
                chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(exp_v));
                chk("dma_rdata", bus.dma_rdata, exp_d);
                chk("wait_cnt", 32'(dbg_wait_cnt), 32'(e_wait));
                chk("owner", 32'(dbg_owner), 32'(cur_owner));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          d_pend;
        bit          c_pend;
        bit          c_en, d_req, rst;
        logic [3:0]  c_wen, d_wen;
        logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

        reset = 1'b1;
        bus.cpu_en = 0; bus.cpu_wen = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_wen = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            dtcm[i] = $urandom;
            ref_mem[i] = dtcm[i];
        end
        dtcm[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        for (int i = 0; i < 3; i++) drive(1, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 32'd0, 32'd0);

        // CPU read of 0x10
        drive(0, 1, 4'd0, 32'h10, 32'd0, 0, 4'd0, 32'd0, 32'd0);
        idle(1);
        // DMA write while CPU idle
        drive(0, 0, 4'd0, 32'd0, 32'd0, 1, 4'hF, 32'h20, 32'h12345678);
        idle(1);
        // collision then CPU idle; DMA read sees the value just written
        drive(0, 1, 4'd0, 32'h30, 32'd0, 1, 4'd0, 32'h20, 32'd0);
        drive(0, 0, 4'd0, 32'd0, 32'd0, 1, 4'd0, 32'h20, 32'd0);
        idle(2);
        // sustained contention: forced grant only with the starvation guard
        for (int i = 0; i < 100; i++) drive(0, 1, 4'd0, 32'h40, 32'd0, 1, 4'd0, 32'h44, 32'd0);
        idle(1);
        // reset right after a granted DMA read
        drive(0, 0, 4'd0, 32'd0, 32'd0, 1, 4'd0, 32'h20, 32'd0);
        drive(1, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 32'd0, 32'd0);
        idle(2);

        // random traffic honouring request-hold rules
        d_pend = 0; c_pend = 0;
        c_en = 0; d_req = 0; c_wen = 0; d_wen = 0;
        c_addr = 0; c_wdata = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63, 0) == 0);
            if (!c_pend) begin
                c_en = ($urandom_range(9, 0) < 6);
                c_wen = rnd_wen(); c_addr = rnd_addr(); c_wdata = $urandom;
            end
            if (!d_pend) begin
                d_req = ($urandom_range(1, 0) == 1);
                d_wen = rnd_wen(); d_addr = rnd_addr(); d_wdata = $urandom;
            end
            drive(rst, c_en, c_wen, c_addr, c_wdata, d_req, d_wen, d_addr, d_wdata);
            c_pend = c_en && e_stall;
            d_pend = d_req && !e_dma;
        end

        idle(3);
        @(negedge clk);
        #1;
        chk("cpu_queue_empty", 32'(cpu_exp_q.size()), 32'd0);
        chk("dma_queue_empty", 32'(dma_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
